// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format geometry, operand classes and the canonical quiet NaN.
package fp_pkg;

    // Operand class carried alongside the mantissa product.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_e;

    // Default format is single precision.
    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int FP_MAX_W  = 128;

    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones, 1, 0...} in the low fp_width() bits.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
        r[man_w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_mant.sv
// Mantissa product pipeline: unsigned MWxMW multiply followed by STAGES registers,
// with a valid bit and an opaque side-band word carried in lock-step.
module fp_mant_mul_pipe #(
    parameter int MW     = 24,
    parameter int STAGES = 2,
    parameter int SIDE_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i_valid,
    input  logic [MW-1:0]     i_a,
    input  logic [MW-1:0]     i_b,
    input  logic [SIDE_W-1:0] i_side,
    output logic              o_valid,
    output logic [2*MW-1:0]   o_prod,
    output logic [SIDE_W-1:0] o_side
);

    logic [2*MW-1:0]   w_prod;
    logic [2*MW-1:0]   r_prod [STAGES];
    logic [SIDE_W-1:0] r_side [STAGES];
    logic [STAGES-1:0] r_vld;

    // The product is formed combinationally; the register chain lets synthesis retime it.
    assign w_prod = {{MW{1'b0}}, i_a} * {{MW{1'b0}}, i_b};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            // First product register captures the raw multiply.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld[s]  <= 1'b0;
                    r_prod[s] <= '0;
                    r_side[s] <= '0;
                end else if (en) begin
                    r_vld[s]  <= i_valid;
                    r_prod[s] <= w_prod;
                    r_side[s] <= i_side;
                end
            end
        end else begin : g_rest
            // Later registers just shift the previous stage along.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld[s]  <= 1'b0;
                    r_prod[s] <= '0;
                    r_side[s] <= '0;
                end else if (en) begin
                    r_vld[s]  <= r_vld[s-1];
                    r_prod[s] <= r_prod[s-1];
                    r_side[s] <= r_side[s-1];
                end
            end
        end
    end

    assign o_valid = r_vld[STAGES-1];
    assign o_prod  = r_prod[STAGES-1];
    assign o_side  = r_side[STAGES-1];

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined FP multiplier: unpack/classify, mantissa product pipe, round-to-nearest-even
// and special-case select. Subnormal inputs read as zero; tiny results flush to zero.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W      = DEF_EXP_W,
    parameter int MAN_W      = DEF_MAN_W,
    parameter int MUL_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   valid_in,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   valid_out,
    output logic [EXP_W+MAN_W:0]   out,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_underflow,
    output logic                   flag_inexact
);

    localparam int W       = fp_width(EXP_W, MAN_W);
    localparam int BIAS    = fp_bias(EXP_W);
    localparam int EXP_MAX = fp_exp_max(EXP_W);
    localparam int EW2     = EXP_W + 2;
    localparam int MW1     = MAN_W + 1;
    localparam int PW      = 2 * MW1;

    localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
    localparam logic [EW2-1:0]      BIAS_X    = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EMAX_S  = EW2'(EXP_MAX);
    localparam logic signed [EW2-1:0] EZERO_S = '0;

    typedef struct packed {
        logic           sign;
        fp_cls_e        cls_a;
        fp_cls_e        cls_b;
        logic [EW2-1:0] esum;   // ea+eb-BIAS, two's complement
    } side_t;

    function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return CLS_ZERO;
        if (&e)      return (m == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORM;
    endfunction

    logic           r1_vld;
    side_t          r1_side;
    logic [MW1-1:0] r1_ma, r1_mb;

    // Stage 1: classify operands, attach hidden bits, pre-add the biased exponents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_vld  <= 1'b0;
            r1_side <= '0;
            r1_ma   <= '0;
            r1_mb   <= '0;
        end else if (en) begin
            r1_vld        <= valid_in;
            r1_side.sign  <= a[W-1] ^ b[W-1];
            r1_side.cls_a <= classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
            r1_side.cls_b <= classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
            r1_side.esum  <= {2'b00, a[W-2 -: EXP_W]} + {2'b00, b[W-2 -: EXP_W]} - BIAS_X;
            r1_ma         <= {1'b1, a[MAN_W-1:0]};
            r1_mb         <= {1'b1, b[MAN_W-1:0]};
        end
    end

    logic          w_m_vld;
    logic [PW-1:0] w_prod;
    side_t         w_m_side;

    fp_mant_mul_pipe #(
        .MW     (MW1),
        .STAGES (MUL_STAGES),
        .SIDE_W ($bits(side_t))
    ) u_mant (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .i_valid (r1_vld),
        .i_a     (r1_ma),
        .i_b     (r1_mb),
        .i_side  (r1_side),
        .o_valid (w_m_vld),
        .o_prod  (w_prod),
        .o_side  (w_m_side)
    );

    logic                   w_msb, w_guard, w_sticky, w_rnd;
    logic [PW-1:0]          w_norm;
    logic [MAN_W-1:0]       w_man;
    logic [MAN_W:0]         w_man_r;
    logic signed [EW2-1:0]  w_e;
    logic                   w_nan_any, w_inf_any, w_zero_any;

    // Normalise so the leading one sits at PW-1; the shifted-in zero cannot disturb sticky.
    assign w_msb    = w_prod[PW-1];
    assign w_norm   = w_msb ? w_prod : (w_prod << 1);
    assign w_man    = w_norm[PW-2 -: MAN_W];
    assign w_guard  = w_norm[PW-2-MAN_W];
    assign w_sticky = |w_norm[PW-3-MAN_W:0];
    assign w_rnd    = w_guard & (w_sticky | w_man[0]);
    // On carry-out the low MAN_W bits are already zero (all-ones + 1).
    assign w_man_r  = {1'b0, w_man} + MW1'(w_rnd);
    assign w_e      = w_m_side.esum + EW2'(w_msb) + EW2'(w_man_r[MAN_W]);

    assign w_nan_any  = (w_m_side.cls_a == CLS_NAN)  || (w_m_side.cls_b == CLS_NAN);
    assign w_inf_any  = (w_m_side.cls_a == CLS_INF)  || (w_m_side.cls_b == CLS_INF);
    assign w_zero_any = (w_m_side.cls_a == CLS_ZERO) || (w_m_side.cls_b == CLS_ZERO);

    logic [W-1:0] w_res;
    logic         w_inv, w_ov, w_uf, w_inx;

    // Result select in priority order: invalid, infinity, zero, overflow, underflow, normal.
    always_comb begin
        w_res = '0;
        w_inv = 1'b0;
        w_ov  = 1'b0;
        w_uf  = 1'b0;
        w_inx = 1'b0;
        if (w_nan_any || (w_inf_any && w_zero_any)) begin
            w_res = QNAN;
            w_inv = 1'b1;
        end else if (w_inf_any) begin
            w_res = {w_m_side.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_zero_any) begin
            w_res = {w_m_side.sign, {(W-1){1'b0}}};
        end else if (w_e >= EMAX_S) begin
            w_res = {w_m_side.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ov  = 1'b1;
            w_inx = 1'b1;
        end else if (w_e <= EZERO_S) begin
            w_res = {w_m_side.sign, {(W-1){1'b0}}};
            w_uf  = 1'b1;
            w_inx = 1'b1;
        end else begin
            w_res = {w_m_side.sign, w_e[EXP_W-1:0], w_man_r[MAN_W-1:0]};
            w_inx = w_guard | w_sticky;
        end
    end

    // Output register: valid follows the pipe; data holds its last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out      <= 1'b0;
            out            <= '0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (en) begin
            valid_out <= w_m_vld;
            if (w_m_vld) begin
                out            <= w_res;
                flag_invalid   <= w_inv;
                flag_overflow  <= w_ov;
                flag_underflow <= w_uf;
                flag_inexact   <= w_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: FP32 and FP16-style instances against an integer-arithmetic model.
module tb_fp_mul_pipe;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        v32 = 1'b0, v16 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        vo32, vo16;
    logic [31:0] o32;
    logic [15:0] o16;
    logic        fi32, fo32, fu32, fx32, fi16, fo16, fu16, fx16;
    logic [3:0]  f32, f16;

    int n_cmp = 0;
    int n_err = 0;

    assign f32 = {fi32, fo32, fu32, fx32};
    assign f16 = {fi16, fo16, fu16, fx16};

    always #5 clk = ~clk;

    fp_mul_pipe dut32 (
        .clk(clk), .rst(rst), .en(en), .valid_in(v32), .a(a32), .b(b32),
        .valid_out(vo32), .out(o32), .flag_invalid(fi32), .flag_overflow(fo32),
        .flag_underflow(fu32), .flag_inexact(fx32)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .MUL_STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .en(en), .valid_in(v16), .a(a16), .b(b16),
        .valid_out(vo16), .out(o16), .flag_invalid(fi16), .flag_overflow(fo16),
        .flag_underflow(fu16), .flag_inexact(fx16)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          due;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer product, rounded by quotient/remainder against half an ulp.
    // fl = {invalid, overflow, underflow, inexact}
    function automatic void ref_mul(input int ew, input int mw, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] fl);
        longint unsigned ea, eb, ma, mb, p, q, rem, half, emax;
        longint e;
        int k;
        logic [31:0] sgn;
        bit za, zb, ia, ib, na, nb;
        emax = (64'd1 << ew) - 1;
        sgn  = 32'(a[ew+mw] ^ b[ew+mw]) << (ew + mw);
        ea = (64'(a) >> mw) & emax;  ma = 64'(a) & ((64'd1 << mw) - 1);
        eb = (64'(b) >> mw) & emax;  mb = 64'(b) & ((64'd1 << mw) - 1);
        za = (ea == 0); ia = (ea == emax) && (ma == 0); na = (ea == emax) && (ma != 0);
        zb = (eb == 0); ib = (eb == emax) && (mb == 0); nb = (eb == emax) && (mb != 0);
        r = '0; fl = '0;
        if (na || nb || (ia && zb) || (za && ib)) begin
            r  = 32'((emax << mw) | (64'd1 << (mw - 1)));
            fl = 4'b1000;
        end else if (ia || ib) begin
            r = sgn | 32'(emax << mw);
        end else if (za || zb) begin
            r = sgn;
        end else begin
            p = ((64'd1 << mw) + ma) * ((64'd1 << mw) + mb);
            e = longint'(ea) + longint'(eb) - ((64'sd1 <<< (ew - 1)) - 1);
            k = mw;
            if (p >= (64'd1 << (2 * mw + 1))) begin k = mw + 1; e = e + 1; end
            q    = p >> k;
            rem  = p - (q << k);
            half = 64'd1 << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << (mw + 1))) begin q = q >> 1; e = e + 1; end
            if (e >= longint'(emax)) begin
                r = sgn | 32'(emax << mw); fl = 4'b0101;
            end else if (e <= 0) begin
                r = sgn; fl = 4'b0011;
            end else begin
                r  = sgn | 32'(longint'(e) << mw) | 32'(q - (64'd1 << mw));
                fl = {3'b000, rem != 0};
            end
        end
    endfunction

    // Random operand biased towards specials and exponent extremes.
    function automatic logic [31:0] rand_op(input int ew, input int mw);
        logic [31:0] s, e, m;
        int emax, k;
        emax = (1 << ew) - 1;
        k = int'($urandom_range(0, 15));
        m = $urandom & ((32'd1 << mw) - 1);
        s = 32'($urandom_range(0, 1));
        case (k)
            0:       e = 0;
            1:       begin e = 32'(emax); m = 0; end
            2:       e = 32'(emax);
            3:       e = 32'($urandom_range(1, 3));
            4:       e = 32'(emax - 1) - 32'($urandom_range(0, 2));
            default: e = 32'($urandom_range(emax / 3, (2 * emax) / 3));
        endcase
        return (s << (ew + mw)) | (e << mw) | m;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; v32 = 1'b0; v16 = 1'b0;
        #1;
        n_cmp++;
        if ({vo32, o32, f32} !== 37'd0) begin
            n_err++;
            $display("FAIL reset32: got v=%b out=%h fl=%b, need all zero", vo32, o32, f32);
        end
        n_cmp++;
        if ({vo16, o16, f16} !== 21'd0) begin
            n_err++;
            $display("FAIL reset16: got v=%b out=%h fl=%b, need all zero", vo16, o16, f16);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Directed FP32 table, one op at a time so latency is checked exactly.
    task automatic test_directed();
        logic [31:0] ta [13] = '{32'h40A00000, 32'h40400000, 32'h3F800001, 32'h3F800800, 32'h7F800000,
                                 32'h7F800001, 32'hFF800000, 32'h00000000, 32'h7F000000, 32'h00800000,
                                 32'h3FFFFFFE, 32'h00800000, 32'h00000000};
        logic [31:0] tb [13] = '{32'h40800000, 32'hC0000000, 32'h3F800001, 32'h3F800800, 32'h00000000,
                                 32'h3F800000, 32'h40000000, 32'hC0000000, 32'h40000000, 32'h3F000000,
                                 32'h3F800001, 32'h00800000, 32'hFF800000};
        logic [31:0] tr [13] = '{32'h41A00000, 32'hC0C00000, 32'h3F800002, 32'h3F801000, 32'h7FC00000,
                                 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7F800000, 32'h00000000,
                                 32'h40000000, 32'h00000000, 32'h7FC00000};
        logic [3:0]  tf [13] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000,
                                 4'b1000, 4'b0000, 4'b0000, 4'b0101, 4'b0011,
                                 4'b0001, 4'b0011, 4'b1000};
        bit early;
        en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            a32 = ta[i]; b32 = tb[i]; v32 = 1'b1;
            tick();
            v32 = 1'b0;
            early = 1'b0;
            for (int t = 1; t < LAT - 1; t++) begin
                tick();
                if (vo32 !== 1'b0) early = 1'b1;
            end
            tick();
            n_cmp++;
            if (early || vo32 !== 1'b1 || o32 !== tr[i] || f32 !== tf[i]) begin
                n_err++;
                $display("FAIL directed[%0d] %h*%h: got early=%b v=%b out=%h fl=%b, need v=1 out=%h fl=%b",
                         i, ta[i], tb[i], early, vo32, o32, f32, tr[i], tf[i]);
            end
        end
        tick();
    endtask

    // Random stream with bubbles; optionally toggle en in a 1,0,0,1 pattern.
    task automatic test_stream(input int n, input bit stall);
        exp_t        q[$];
        int          n_en;
        logic [31:0] r, prev_o;
        logic [3:0]  f, prev_f;
        logic        prev_v;
        bit          cur_en;
        n_en = 0;
        for (int i = 0; i < n + 3 * LAT + 4; i++) begin
            cur_en = stall ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
            en  = cur_en;
            v32 = (i < n) && ($urandom_range(0, 3) != 0);
            a32 = rand_op(8, 23);
            b32 = rand_op(8, 23);
            if (cur_en && v32) begin
                ref_mul(8, 23, a32, b32, r, f);
                q.push_back('{r, f, n_en + LAT});
            end
            prev_v = vo32; prev_o = o32; prev_f = f32;
            tick();
            if (cur_en) begin
                n_en++;
                n_cmp++;
                if (q.size() > 0 && q[0].due == n_en) begin
                    if (vo32 !== 1'b1 || o32 !== q[0].res || f32 !== q[0].fl) begin
                        n_err++;
                        $display("FAIL stream op @%0d: got v=%b out=%h fl=%b, need v=1 out=%h fl=%b",
                                 n_en, vo32, o32, f32, q[0].res, q[0].fl);
                    end
                    void'(q.pop_front());
                end else if (vo32 !== 1'b0) begin
                    n_err++;
                    $display("FAIL stream bubble @%0d: got v=%b, need v=0", n_en, vo32);
                end
            end else begin
                n_cmp++;
                if ({vo32, o32, f32} !== {prev_v, prev_o, prev_f}) begin
                    n_err++;
                    $display("FAIL stall hold: got v=%b out=%h fl=%b, need v=%b out=%h fl=%b",
                             vo32, o32, f32, prev_v, prev_o, prev_f);
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL stream drain: got %0d ops still pending, need 0", q.size());
        end
        en = 1'b1; v32 = 1'b0;
        tick();
    endtask

    // Async reset with three ops in flight: immediate clear, nothing dropped re-emerges.
    task automatic test_async_reset();
        bit leaked;
        en = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            a32 = 32'h40000000 + 32'(i << 20); b32 = 32'h3F800000; v32 = 1'b1;
            tick();
        end
        v32 = 1'b0;
        n_cmp++;
        if (vo32 !== 1'b1 || o32 !== 32'h40000000) begin
            n_err++;
            $display("FAIL pre-reset op: got v=%b out=%h, need v=1 out=40000000", vo32, o32);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({vo32, o32, f32} !== 37'd0) begin
            n_err++;
            $display("FAIL async reset: got v=%b out=%h fl=%b, need all zero", vo32, o32, f32);
        end
        tick();
        rst = 1'b0;
        leaked = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            if (vo32 !== 1'b0) leaked = 1'b1;
        end
        n_cmp++;
        if (leaked) begin
            n_err++;
            $display("FAIL reset drop: got a dropped op on valid_out, need none");
        end
    endtask

    // Half-width format: directed 5x4 then a back-to-back random run.
    task automatic test_half();
        logic [31:0] r;
        logic [3:0]  f;
        logic [15:0] er [24];
        logic [3:0]  ef [24];
        int idx;
        en = 1'b1;
        a16 = 16'h4500; b16 = 16'h4400; v16 = 1'b1;
        tick();
        v16 = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (vo16 !== 1'b1 || o16 !== 16'h4D00 || f16 !== 4'b0000) begin
            n_err++;
            $display("FAIL half 5x4: got v=%b out=%h fl=%b, need v=1 out=4D00 fl=0000", vo16, o16, f16);
        end
        tick();
        for (int i = 0; i < 24 + LAT - 1; i++) begin
            if (i < 24) begin
                a16 = 16'(rand_op(5, 10)); b16 = 16'(rand_op(5, 10)); v16 = 1'b1;
                ref_mul(5, 10, {16'h0, a16}, {16'h0, b16}, r, f);
                er[i] = r[15:0]; ef[i] = f;
            end else begin
                v16 = 1'b0;
            end
            tick();
            idx = i - (LAT - 1);
            if (idx >= 0) begin
                n_cmp++;
                if (vo16 !== 1'b1 || o16 !== er[idx] || f16 !== ef[idx]) begin
                    n_err++;
                    $display("FAIL half rand[%0d]: got v=%b out=%h fl=%b, need v=1 out=%h fl=%b",
                             idx, vo16, o16, f16, er[idx], ef[idx]);
                end
            end
        end
        tick();
        n_cmp++;
        if (vo16 !== 1'b0) begin
            n_err++;
            $display("FAIL half tail bubble: got v=%b, need v=0", vo16);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream(200, 1'b0);
        test_stream(200, 1'b1);
        test_async_reset();
        test_half();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the successor to the fixed single-precision multiplier: exponent and mantissa widths are configurable, the multiplier pipeline depth is configurable, and a valid/enable handshake is provided. It adds round-to-nearest-even and exception flags, and correctly handles inf*0. It sits in the FP datapath between operand fetch and writeback, and accepts one operation per enabled cycle.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa field width, without the hidden bit (>=2)
MUL_STAGES, 2, register stages inside the mantissa product (>=1)
Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; LATENCY = MUL_STAGES+2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  pipeline advance; when 0, every pipeline register holds
valid_in  in  1  a,b carry an operation this cycle (sampled only when en=1)
a  in  W  operand A {sign, exp, man}
b  in  W  operand B
valid_out  out  1  out and flags are valid
out  out  W  product
flag_invalid  out  1  NaN operand or inf*0
flag_overflow  out  1  result rounded to infinity from finite inputs
flag_underflow  out  1  nonzero finite result flushed to zero
flag_inexact  out  1  rounding discarded nonzero bits (includes overflow and underflow)

Behaviour:
- Reset (async, rst=1) clears every valid bit, out and all flags to 0 immediately. An operation in flight is dropped, not completed. After rst falls, the first valid_out can appear no earlier than LATENCY enabled edges after a valid_in.
- Latency: an op sampled with en=1 and valid_in=1 appears on valid_out after exactly LATENCY enabled edges. Throughput is 1 op per enabled cycle.
- Pipeline valid bits advance only when en=1. Outputs stay stable while en=0. Bubbles (valid_in=0) propagate as valid_out=0; out and flags are don't-care then, but are held at their last value.
- Stage 1 (unpack/classify, registered):
  - sign = sa^sb.
  - Classify each operand as zero (exp==0; subnormals are flushed to zero, DAZ), inf (exp all-ones, man==0) or NaN (exp all-ones, man!=0).
  - Mantissas get the hidden bit: {1,man}, MAN_W+1 bits.
- Stages 2..MUL_STAGES+1: (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits. Classification, sign and exponent sum are carried in lock-step.
- Exponent: signed, EXP_W+2 bits. e = ea+eb-BIAS, plus 1 if product MSB is set. Normalisation shifts the product right 1 when its MSB is set.
- Rounding: round-to-nearest, ties-to-even.
  - Use guard bit plus sticky (OR of all lower bits).
  - A mantissa carry-out sets mantissa=0 and increments e.
- Final stage (registered output), in priority order:
  1. Any NaN, or inf*zero: out = quiet NaN {0, all-ones, 1, 0...}, invalid=1.
  2. Any inf: out = {sign, all-ones, 0}.
  3. Any zero: out = {sign, 0, 0}.
  4. e >= 2^EXP_W-1 after rounding: out = {sign, inf}, overflow=1, inexact=1.
  5. e <= 0: out = {sign, 0, 0}, underflow=1, inexact=1 (flush-to-zero, no subnormal output).
  6. Otherwise: normal {sign, e[EXP_W-1:0], rounded man}; inexact = guard|sticky.
- Flags for the special cases in 1–3 are 0 except invalid.

Decomposition:
- Shared package fp_pkg: EXP_W/MAN_W-derived localparams (W, BIAS, EXP_MAX), the class encoding (ZERO/NORM/INF/NAN), and the canonical QNaN constant function.
- One sub-module: fp_mant_mul_pipe (parametrised width and MUL_STAGES, with en and valid pass-through) for the product pipeline. Unpack, round and select stay in fp_mul_pipe.

Test Plan (defaults, FP32, en=1 unless noted):
1. 0x40A00000 x 0x40800000 (5x4) -> 0x41A00000 after 4 cycles. Also 0x40400000 x 0xC0000000 -> 0xC0C00000. Flags all 0.
2. Rounding:
   - 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1.
   - Tie: 0x3F800800 x 0x3F800800 -> 0x3F801000 (rounds to even), inexact=1.
3. Specials:
   - 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1.
   - 0x7F800001 x 0x3F800000 -> 0x7FC00000, invalid=1.
   - 0xFF800000 x 0x40000000 -> 0xFF800000.
   - 0x00000000 x 0xC0000000 -> 0x80000000.
4. Range:
   - 0x7F000000 x 0x40000000 -> 0x7F800000, overflow=1, inexact=1.
   - 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1, inexact=1.
5. Handshake: back-to-back valid ops with en toggled 1,0,0,1 mid-stream -> results keep order, each emerges after exactly 4 enabled edges, outputs frozen while en=0. Bubbles give valid_out=0.
6. Assert rst with 3 ops in flight -> valid_out=0 immediately (async), none of the dropped ops emerge. Re-run with EXP_W=5, MAN_W=10: 0x4500 x 0x4400 (5x4) -> 0x4D00.
